mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_id_fifo.sv | 94 +++++++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory arbiter slice.
//   calc_id_width : bits needed to encode a host index (never less than 1)
//   host_idx_t    : host index type, wide enough for the largest host count
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned MaxHosts = 8;

    // Width of an index into 'num' hosts; a single host still needs one bit.
    function automatic int unsigned calc_id_width(input int unsigned num);
        int unsigned w;
        if (num > 32'd1) begin
            w = $clog2(num);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

    localparam int unsigned MaxHostIdWidth = calc_id_width(MaxHosts);

    typedef logic [MaxHostIdWidth-1:0] host_idx_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// mem_arb_id_fifo
// In-order FIFO of host indices for requests accepted by memory but not yet
// answered. Push is ignored when full, pop is ignored when empty.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push, push_id : enqueue push_id
//   pop           : dequeue the head entry
//   full, empty   : occupancy flags
//   head          : oldest entry (valid when !empty)
// ---------------------------------------------------------------------------
module mem_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] push_id,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);

    localparam int unsigned PtrWidth = (Depth > 32'd1) ? $clog2(Depth) : 32'd1;
    localparam int unsigned CntWidth = $clog2(Depth + 32'd1);

    typedef logic [PtrWidth-1:0] ptr_t;
    typedef logic [CntWidth-1:0] cnt_t;

    logic [Depth-1:0][Width-1:0] slot_r;
    ptr_t                        wr_ptr_r;
    ptr_t                        rd_ptr_r;
    cnt_t                        count_r;
    logic                        push_ok_s;
    logic                        pop_ok_s;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t n;
        if (p == ptr_t'(Depth - 32'd1)) begin
            n = '0;
        end else begin
            n = p + ptr_t'(1);
        end
        return n;
    endfunction

    assign full      = (count_r == cnt_t'(Depth));
    assign empty     = (count_r == cnt_t'(0));
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Head mux: select the slot addressed by the read pointer
    always_comb begin
        head = '0;
        for (int i = 0; i < int'(Depth); i++) begin
            head = (rd_ptr_r == ptr_t'(i)) ? slot_r[i] : head;
        end
    end

    // Storage: write the slot addressed by the write pointer on push
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_r <= '0;
        end else begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (push_ok_s && (wr_ptr_r == ptr_t'(i))) begin
                    slot_r[i] <= push_id;
                end else begin
                    slot_r[i] <= slot_r[i];
                end
            end
        end
    end

    // Pointers and occupancy count; simultaneous push and pop keep the count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= push_ok_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r <= pop_ok_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + cnt_t'(1);
                2'b01:   count_r <= count_r - cnt_t'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter sharing one memory request port among NumHosts hosts.
// Winner selection, grant and response routing are combinational; the
// round-robin pointer, the in-order ID FIFO and the error flag are registered.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   host_req/we/be/addr/wdata_i : per-host request fields
//   host_gnt_o              : one-hot grant, only in an accepted cycle
//   host_rvalid_o           : one-hot response valid, routed by the ID FIFO
//   host_rdata_o            : shared response data, zero when no rvalid
//   mem_*                   : memory request (req/gnt) and response ports
//   err_o                   : sticky flag, response arrived with nothing pending
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NumHosts       = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumHosts-1:0]                    host_req_i,
    output logic [NumHosts-1:0]                    host_gnt_o,
    input  logic [NumHosts-1:0]                    host_we_i,
    input  logic [NumHosts-1:0][DataWidth/8-1:0]   host_be_i,
    input  logic [NumHosts-1:0][AddrWidth-1:0]     host_addr_i,
    input  logic [NumHosts-1:0][DataWidth-1:0]     host_wdata_i,
    output logic [NumHosts-1:0]                    host_rvalid_o,
    output logic [DataWidth-1:0]                   host_rdata_o,
    output logic                                   mem_req_o,
    input  logic                                   mem_gnt_i,
    output logic                                   mem_we_o,
    output logic [DataWidth/8-1:0]                 mem_be_o,
    output logic [AddrWidth-1:0]                   mem_addr_o,
    output logic [DataWidth-1:0]                   mem_wdata_o,
    input  logic                                   mem_rvalid_i,
    input  logic [DataWidth-1:0]                   mem_rdata_i,
    output logic                                   err_o
);

    localparam int unsigned HostIdWidth = calc_id_width(NumHosts);

    host_idx_t                rr_ptr_r;
    host_idx_t                rr_ptr_nxt_s;
    host_idx_t                winner_s;
    host_idx_t                head_idx_s;
    logic [NumHosts-1:0]      mask_s;
    logic [NumHosts-1:0]      req_masked_s;
    logic [NumHosts-1:0]      req_pick_s;
    logic                     any_req_s;
    logic                     mem_req_s;
    logic                     accept_s;
    logic                     pop_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic [HostIdWidth-1:0]   fifo_push_id_s;
    logic [HostIdWidth-1:0]   fifo_head_s;
    logic                     err_r;

    // Round-robin winner: lowest requester at or above rr_ptr, else wrap to
    // the lowest requester overall. Scanning downwards leaves the lowest hit.
    always_comb begin
        mask_s   = '0;
        winner_s = '0;
        for (int i = 0; i < int'(NumHosts); i++) begin
            mask_s[i] = (i >= int'(rr_ptr_r));
        end
        req_masked_s = host_req_i & mask_s;
        req_pick_s   = (|req_masked_s) ? req_masked_s : host_req_i;
        for (int i = int'(NumHosts) - 1; i >= 0; i--) begin
            winner_s = req_pick_s[i] ? host_idx_t'(i) : winner_s;
        end
        rr_ptr_nxt_s = (winner_s == host_idx_t'(NumHosts - 32'd1)) ?
                       host_idx_t'(0) : (winner_s + host_idx_t'(1));
    end

    // Capacity is judged on the count before any same-cycle pop, so a full
    // FIFO blocks the request even while a response is draining it.
    assign any_req_s      = |host_req_i;
    assign mem_req_s      = rst_ni & any_req_s & ~fifo_full_s;
    assign accept_s       = mem_req_s & mem_gnt_i;
    assign pop_s          = rst_ni & mem_rvalid_i & ~fifo_empty_s;
    assign fifo_push_id_s = winner_s[HostIdWidth-1:0];
    assign head_idx_s     = host_idx_t'(fifo_head_s);

    mem_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (HostIdWidth)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (accept_s),
        .push_id (fifo_push_id_s),
        .pop     (pop_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .head    (fifo_head_s)
    );

    // Output routing: grant/rvalid decode and the winner's request fields.
    // Everything is forced to zero while reset is asserted.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        mem_we_o      = 1'b0;
        mem_be_o      = '0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        for (int i = 0; i < int'(NumHosts); i++) begin
            host_gnt_o[i]    = accept_s & (winner_s == host_idx_t'(i));
            host_rvalid_o[i] = pop_s & (head_idx_s == host_idx_t'(i));
            mem_we_o    = (rst_ni && (winner_s == host_idx_t'(i))) ? host_we_i[i]    : mem_we_o;
            mem_be_o    = (rst_ni && (winner_s == host_idx_t'(i))) ? host_be_i[i]    : mem_be_o;
            mem_addr_o  = (rst_ni && (winner_s == host_idx_t'(i))) ? host_addr_i[i]  : mem_addr_o;
            mem_wdata_o = (rst_ni && (winner_s == host_idx_t'(i))) ? host_wdata_i[i] : mem_wdata_o;
        end
        mem_req_o    = mem_req_s;
        host_rdata_o = pop_s ? mem_rdata_i : '0;
    end

    // Round-robin pointer: moves past the winner only on an accepted request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_r <= '0;
        end else if (accept_s) begin
            rr_ptr_r <= rr_ptr_nxt_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Sticky error: a response with no pending request; only reset clears it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (mem_rvalid_i && fifo_empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int NH = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    logic                      clk_i;
    logic                      rst_ni;
    logic [NH-1:0]             host_req_i;
    logic [NH-1:0]             host_gnt_o;
    logic [NH-1:0]             host_we_i;
    logic [NH-1:0][DW/8-1:0]   host_be_i;
    logic [NH-1:0][AW-1:0]     host_addr_i;
    logic [NH-1:0][DW-1:0]     host_wdata_i;
    logic [NH-1:0]             host_rvalid_o;
    logic [DW-1:0]             host_rdata_o;
    logic                      mem_req_o;
    logic                      mem_gnt_i;
    logic                      mem_we_o;
    logic [DW/8-1:0]           mem_be_o;
    logic [AW-1:0]             mem_addr_o;
    logic [DW-1:0]             mem_wdata_o;
    logic                      mem_rvalid_i;
    logic [DW-1:0]             mem_rdata_i;
    logic                      err_o;

    int     pass_cnt = 0;
    int     total_cnt = 0;
    int     exp_rr;
    int     sb_q[$];
    logic   exp_err;
    string  phase;

    mem_arbiter #(
        .NumHosts       (NH),
        .AddrWidth      (AW),
        .DataWidth      (DW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .host_req_i    (host_req_i),
        .host_gnt_o    (host_gnt_o),
        .host_we_i     (host_we_i),
        .host_be_i     (host_be_i),
        .host_addr_i   (host_addr_i),
        .host_wdata_i  (host_wdata_i),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .err_o         (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    endtask

    // One clock of stimulus; the model predicts grant, mem_req, response
    // routing and the error flag, then updates its pointer and scoreboard.
    task automatic cycle(input logic [NH-1:0] req, input logic gnt, input logic rv,
                         input logic [DW-1:0] rd, output logic [NH-1:0] obs_gnt);
        logic [NH-1:0] sh;
        logic [NH-1:0] exp_gnt;
        logic [NH-1:0] exp_rv;
        logic [DW-1:0] exp_rd;
        logic          exp_mreq;
        logic          acc;
        int            win;
        @(negedge clk_i);
        host_req_i   = req;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        #2;
        win = -1;
        for (int k = 0; k < NH; k++) begin
            sh = req >> ((exp_rr + k) % NH);
            if (win < 0 && sh[0]) win = (exp_rr + k) % NH;
        end
        exp_mreq = (req != '0) && (sb_q.size() < MO);
        acc      = exp_mreq && gnt;
        exp_gnt  = acc ? (NH'(1) << win) : '0;
        if (rv && sb_q.size() > 0) begin
            exp_rv = NH'(1) << sb_q[0];
            exp_rd = rd;
        end else begin
            exp_rv = '0;
            exp_rd = '0;
        end
        check("gnt", host_gnt_o, exp_gnt);
        check("mem_req", mem_req_o, exp_mreq);
        check("rvalid", host_rvalid_o, exp_rv);
        check("rdata", host_rdata_o, exp_rd);
        check("err", err_o, exp_err);
        obs_gnt = host_gnt_o;
        if (rv && sb_q.size() == 0) exp_err = 1'b1;
        if (rv && sb_q.size() > 0) void'(sb_q.pop_front());
        if (acc) begin
            sb_q.push_back(win);
            exp_rr = (win + 1) % NH;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        rst_ni       = 1'b0;
        host_req_i   = '1;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFF_FFFF;
        #2;
        check("rst_gnt", host_gnt_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_rvalid", host_rvalid_o, 0);
        check("rst_rdata", host_rdata_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_err", err_o, 0);
        @(negedge clk_i);
        #2;
        check("rst_rr", dut.rr_ptr_r, 0);
        check("rst_fifo_empty", dut.fifo_empty_s, 1);
        @(negedge clk_i);
        host_req_i   = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        rst_ni       = 1'b1;
        sb_q.delete();
        exp_rr  = 0;
        exp_err = 1'b0;
    endtask

    initial begin
        logic [NH-1:0] g;
        int            n;
        rst_ni       = 1'b0;
        host_req_i   = '0;
        host_we_i    = '0;
        host_be_i    = '0;
        host_addr_i  = '0;
        host_wdata_i = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        exp_rr       = 0;
        exp_err      = 1'b0;

        phase = "reset";
        reset_dut();

        // Both hosts request, memory answers one cycle after each accept
        phase = "alternate";
        cycle(2'b11, 1'b1, 1'b0, 32'h0, g);            check("g0", g, 2'b01);
        cycle(2'b11, 1'b1, 1'b1, 32'h1111_0000, g);    check("g1", g, 2'b10);
        cycle(2'b11, 1'b1, 1'b1, 32'h2222_0000, g);    check("g2", g, 2'b01);
        cycle(2'b11, 1'b1, 1'b1, 32'h3333_0000, g);    check("g3", g, 2'b10);
        cycle(2'b00, 1'b0, 1'b1, 32'h4444_0000, g);

        // Host 1 read routed back only to host 1
        phase = "read_h1";
        host_addr_i[1] = 32'h0010_0040;
        host_we_i      = 2'b00;
        cycle(2'b10, 1'b1, 1'b0, 32'h0, g);
        check("gnt", g, 2'b10);
        check("addr", mem_addr_o, 32'h0010_0040);
        check("we", mem_we_o, 0);
        cycle(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, g);
        check("rvalid_h1", host_rvalid_o, 2'b10);
        check("rdata_h1", host_rdata_o, 32'hDEAD_BEEF);
        cycle(2'b00, 1'b0, 1'b0, 32'h0, g);
        check("err_clear", err_o, 0);

        // Host 0 write fields forwarded to memory
        phase = "write_h0";
        host_we_i       = 2'b01;
        host_be_i[0]    = 4'b0011;
        host_addr_i[0]  = 32'h0000_1000;
        host_wdata_i[0] = 32'hA5A5_5A5A;
        cycle(2'b01, 1'b1, 1'b0, 32'h0, g);
        check("we", mem_we_o, 1);
        check("be", mem_be_o, 4'b0011);
        check("addr", mem_addr_o, 32'h0000_1000);
        check("wdata", mem_wdata_o, 32'hA5A5_5A5A);
        cycle(2'b00, 1'b0, 1'b1, 32'h0, g);
        host_we_i = 2'b00;

        // Memory withholds responses: only MaxOutstanding accepts
        phase = "full";
        n = 0;
        for (int c = 0; c < 4; c++) begin
            cycle(2'b11, 1'b1, 1'b0, 32'h0, g);
            if (g != '0) n++;
        end
        check("two_accepts", n, 2);
        cycle(2'b11, 1'b1, 1'b1, 32'h0000_0055, g);
        check("no_accept_on_pop", g, 2'b00);
        cycle(2'b11, 1'b1, 1'b0, 32'h0, g);
        check("accept_after_pop", g, 2'b10);
        cycle(2'b00, 1'b0, 1'b1, 32'h0000_0066, g);
        cycle(2'b00, 1'b0, 1'b1, 32'h0000_0077, g);

        // Memory stalls: no grant, pointer holds, grant when mem_gnt_i rises
        phase = "stall";
        cycle(2'b01, 1'b1, 1'b0, 32'h0, g);
        cycle(2'b00, 1'b0, 1'b1, 32'h0000_0088, g);
        check("rr_pre", dut.rr_ptr_r, exp_rr);
        for (int c = 0; c < 3; c++) begin
            cycle(2'b01, 1'b0, 1'b0, 32'h0, g);
            check("stall_gnt", g, 2'b00);
        end
        check("rr_hold", dut.rr_ptr_r, 1);
        cycle(2'b01, 1'b1, 1'b0, 32'h0, g);
        check("gnt_on_rise", g, 2'b01);
        cycle(2'b00, 1'b0, 1'b1, 32'h0000_0099, g);

        // Unsolicited response: no rvalid, sticky error until reset
        phase = "spurious";
        cycle(2'b00, 1'b0, 1'b1, 32'hBAD0_0BAD, g);
        check("no_rvalid", host_rvalid_o, 2'b00);
        cycle(2'b00, 1'b0, 1'b0, 32'h0, g);
        cycle(2'b01, 1'b1, 1'b0, 32'h0, g);
        cycle(2'b00, 1'b0, 1'b1, 32'h0, g);
        check("err_sticky", err_o, 1);
        phase = "reset2";
        reset_dut();
        cycle(2'b00, 1'b0, 1'b0, 32'h0, g);

        // Reset with two requests outstanding; the late response is an error
        phase = "reset_outstanding";
        cycle(2'b01, 1'b1, 1'b0, 32'h0, g);
        cycle(2'b01, 1'b1, 1'b0, 32'h0, g);
        check("rr_before", dut.rr_ptr_r, 1);
        check("fifo_full", dut.fifo_empty_s, 0);
        reset_dut();
        phase = "after_reset";
        #2;
        check("rr_after", dut.rr_ptr_r, 0);
        check("fifo_empty", dut.fifo_empty_s, 1);
        cycle(2'b00, 1'b0, 1'b1, 32'h0000_1234, g);
        check("late_rvalid", host_rvalid_o, 2'b00);
        cycle(2'b00, 1'b0, 1'b0, 32'h0, g);
        check("late_err", err_o, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
